shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//  Shares one combinational 24-bit mantissa right shifter among N_REQ Vector ALU requesters
//  (e.g. FP add lanes doing exponent alignment). Arbitrates round-robin with valid/ready handshakes.
//  Drives the shifter through dedicated ports and registers the result plus sticky bit.
//  Returns the result tagged with the requester ID through a single-entry output buffer.
// PARAMETERS
//  N_REQ  4   number of requesters (2..8)
//  ID_W   2   requester ID width, = clog2(N_REQ)
// PORTS
//  clk         in   1          clock, all state updates on rising edge
//  rst         in   1          synchronous, active-high reset
//  req_valid   in   N_REQ      per-requester request valid
//  req_mant    in   N_REQ*24   packed mantissas, requester i at [24*i+23:24*i]
//  req_amt     in   N_REQ*8    packed shift amounts, requester i at [8*i+7:8*i]
//  req_ready   out  N_REQ      one-hot grant; request i accepted when req_valid[i]&req_ready[i]
//  shf_a       out  24         mantissa to the shared shifter
//  shf_amt     out  8          shift amount to the shared shifter
//  shf_out     in   24         shifter result (combinational, = shf_a >> shf_amt, 0 if amt>=24)
//  rsp_valid   out  1          response valid
//  rsp_ready   in   1          response consumer ready
//  rsp_data    out  24         registered shifted mantissa
//  rsp_id      out  ID_W       index of the requester that produced rsp_data
//  rsp_sticky  out  1          OR of all mantissa bits shifted out
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_sticky=0, rr_ptr=0. Any pending response is dropped.
//  - can_accept = !rsp_valid | rsp_ready, a combinational signal.
//  - Arbitration is combinational. Search order is rr_ptr, rr_ptr+1, ... wrapping mod N_REQ.
//    The first i with req_valid[i] wins and gets grant[i]=1.
//    req_ready = can_accept ? grant : 0. At most one bit is set. req_ready never depends on rsp_data.
//  - Shifter drive: with an active grant g, shf_a=req_mant[g] and shf_amt=req_amt[g].
//    With no grant, shf_a=0 and shf_amt=0.
//  - Sticky: sticky = |(req_mant[g] & mask).
//    For amt<24, mask=(1<<amt)-1. For amt>=24, mask=24'hFFFFFF. amt=0 gives sticky=0.
//  - Accept (grant valid & can_accept) at edge T:
//    rsp_data<=shf_out, rsp_id<=g, rsp_sticky<=sticky, rsp_valid<=1, rr_ptr<=(g+1) mod N_REQ.
//  - Latency: exactly 1 cycle from accept to rsp_valid. Throughput is 1 per cycle when rsp_ready is held high.
//  - Drain with no accept (rsp_valid & rsp_ready & no request): rsp_valid<=0, rsp_data/rsp_id/rsp_sticky hold.
//  - Simultaneous drain + accept: the new response replaces the old one in the same edge, with no bubble.
//  - Backpressure (rsp_valid & !rsp_ready): req_ready=0 and rr_ptr holds. All rsp_* outputs are stable.
//  - Requesters must hold valid/mant/amt stable until accepted. The arbiter does not register requests.
//  - rr_ptr advances only on accept, so an idle cycle keeps fairness state.
//  - Starvation bound: a continuously valid requester is granted within N_REQ accepts.
//  - No other state: two effective states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
//    EMPTY->FULL on accept. FULL->EMPTY on drain without accept. FULL->FULL on drain+accept or stall.
// TESTING
//  1. Reset, then req0 valid, mant=24'hABCDEF, amt=4, rsp_ready=1.
//     -> req_ready=0001. Next cycle rsp_valid=1, rsp_data=24'h0ABCDE, rsp_id=0, rsp_sticky=1.
//  2. All 4 requesters valid continuously with rsp_ready=1.
//     -> grants cycle 0,1,2,3,0 and rsp_id follows one cycle later, with no idle cycles.
//  3. amt=0, mant=24'h800001 -> rsp_data=24'h800001, sticky=0.
//     amt=24 -> rsp_data=0, sticky=1. amt=200 with mant=0 -> rsp_data=0, sticky=0.
//  4. Response pending with rsp_ready=0 for 3 cycles while req1,req2 are valid.
//     -> req_ready=0 and rsp_* stable. When rsp_ready rises, req1 is granted in that same cycle.
//  5. Assert rst while rsp_valid=1 and req0 is valid.
//     -> next cycle rsp_valid=0, rr_ptr=0. After rst drops, req0 is granted first.
//  6. Only req3 valid, then only req1. -> rr_ptr wraps 0->3 grant->0. req1 granted next, rsp_id=1.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 24-bit mantissa right shifter among N_REQ requesters.
// The result, sticky bit and requester ID are held in a single-entry response buffer.
module shift_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*24-1:0]   req_mant,
  input  logic [N_REQ*8-1:0]    req_amt,
  output logic [N_REQ-1:0]      req_ready,
  output logic [23:0]           shf_a,
  output logic [7:0]            shf_amt,
  input  logic [23:0]           shf_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [23:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_sticky
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready may depend on valid, valid never depends on ready, and payload is held until taken.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [23:0]     data_q, data_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            sticky_q, sticky_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic            can_accept;
  logic            grant_vld;
  logic            accept;
  logic [ID_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant;
  logic [23:0]     sel_mant;
  logic [7:0]      sel_amt;
  logic [23:0]     mask;
  logic            sticky;

  assign can_accept = (state_q == EMPTY) || rsp_ready;

  // First valid requester at or after rr_ptr wins, wrapping mod N_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  assign accept    = grant_vld && can_accept;
  assign req_ready = can_accept ? grant : '0;

  assign sel_mant = grant_vld ? req_mant[24*int'(grant_idx) +: 24] : 24'd0;
  assign sel_amt  = grant_vld ? req_amt[8*int'(grant_idx) +: 8] : 8'd0;
  assign shf_a    = sel_mant;
  assign shf_amt  = sel_amt;

  // Any bit below the shift amount falls off the end; amounts of 24+ lose everything.
  assign mask   = (sel_amt >= 8'd24) ? 24'hFFFFFF : ((24'd1 << sel_amt[4:0]) - 24'd1);
  assign sticky = |(sel_mant & mask);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    id_d     = id_q;
    sticky_d = sticky_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      state_d  = FULL;
      data_d   = shf_out;
      id_d     = grant_idx;
      sticky_d = sticky;
      rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      id_q     <= '0;
      sticky_q <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      id_q     <= id_d;
      sticky_q <= sticky_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_data   = data_q;
  assign rsp_id     = id_q;
  assign rsp_sticky = sticky_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and random stimulus for shift_arbiter with a round-robin reference model
// feeding an expected-response queue, plus an external behavioural shifter.
module tb_shift_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*24-1:0] req_mant;
  logic [N*8-1:0]  req_amt;
  logic [N-1:0]    req_ready;
  logic [23:0]     shf_a;
  logic [7:0]      shf_amt;
  logic [23:0]     shf_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [23:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_sticky;

  int vectors = 0;
  int miscompares = 0;
  logic [26:0] exp_q[$];
  logic [26:0] last_exp;
  logic [1:0]  m_ptr;
  bit          mon_en;

  shift_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mant(req_mant), .req_amt(req_amt), .req_ready(req_ready),
    .shf_a(shf_a), .shf_amt(shf_amt), .shf_out(shf_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_sticky(rsp_sticky)
  );

  // Clock / reset environment and the shared combinational shifter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign shf_out = (shf_amt >= 8'd24) ? 24'd0 : (shf_a >> shf_amt);

  function automatic logic [23:0] data_m(input logic [23:0] m, input logic [7:0] a);
    return (a >= 8'd24) ? 24'd0 : (m >> a);
  endfunction

  function automatic logic sticky_m(input logic [23:0] m, input logic [7:0] a);
    logic s;
    s = 1'b0;
    for (int b = 0; b < 24; b++)
      if (b < int'(a)) s = s | m[b];
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [23:0] m, input logic [7:0] a);
    req_valid[i]          = v;
    req_mant[i*24 +: 24]  = m;
    req_amt[i*8 +: 8]     = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input int i, input logic [23:0] m, input logic [7:0] a);
    bit done;
    done = 1'b0;
    set_req(i, 1'b1, m, a);
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (req_ready[i]) done = 1'b1;
      tick();
    end
    req_valid[i] = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL issue_timeout: requester %0d observed no grant expected grant within 20 cycles", i);
    end
  endtask

  // Scoreboard: reference round-robin model, expected queue and response checks.
  logic [26:0] cur, nv;
  logic        found, ca;
  logic [1:0]  g, gi;
  logic [3:0]  exp_rr;
  logic [23:0] mm;
  logic [7:0]  aa;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        last_exp = '0;
        m_ptr    = '0;
      end else begin
        if (exp_q.size() > 0) begin
          cur = exp_q[0];
          check("rsp_valid_full", rsp_valid, 1);
        end else begin
          cur = last_exp;
          check("rsp_valid_empty", rsp_valid, 0);
        end
        check("rsp_data", rsp_data, cur[23:0]);
        check("rsp_sticky", rsp_sticky, cur[24]);
        check("rsp_id", rsp_id, cur[26:25]);

        ca    = (exp_q.size() == 0) || rsp_ready;
        found = 1'b0;
        g     = '0;
        for (int k = 0; k < N; k++) begin
          gi = m_ptr + 2'(k);
          if (!found && req_valid[gi]) begin
            found = 1'b1;
            g     = gi;
          end
        end
        exp_rr = (found && ca) ? (4'b0001 << g) : 4'b0000;
        check("req_ready", req_ready, exp_rr);
        mm = found ? req_mant[g*24 +: 24] : 24'd0;
        aa = found ? req_amt[g*8 +: 8] : 8'd0;
        check("shf_a", shf_a, mm);
        check("shf_amt", shf_amt, aa);

        if (exp_q.size() > 0 && rsp_ready) void'(exp_q.pop_front());
        if (found && ca) begin
          nv = {g, sticky_m(mm, aa), data_m(mm, aa)};
          exp_q.push_back(nv);
          last_exp = nv;
          m_ptr    = g + 2'd1;
        end
      end
    end
  end

  logic [23:0] t3_m[4]  = '{24'h800001, 24'h000001, 24'h000000, 24'h800000};
  logic [7:0]  t3_a[4]  = '{8'd0, 8'd24, 8'd200, 8'd23};
  logic [23:0] t3_d[4]  = '{24'h800001, 24'h000000, 24'h000000, 24'h000001};
  logic        t3_s[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [N-1:0] hs;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_mant = '0;
    req_amt = '0;
    rsp_ready = 1'b0;
    mon_en = 1'b0;
    last_exp = '0;
    m_ptr = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_valid", rsp_valid, 0);
    check("reset_data", rsp_data, 0);
    check("reset_id", rsp_id, 0);
    check("reset_sticky", rsp_sticky, 0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Single request from requester 0
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 24'hABCDEF, 8'd4);
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_valid", rsp_valid, 1);
    check("t1_data", rsp_data, 24'h0ABCDE);
    check("t1_id", rsp_id, 0);
    check("t1_sticky", rsp_sticky, 1);
    tick();

    // All requesters continuously valid: back-to-back round robin
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 24'($urandom_range(0, 24'hFFFFFF)), 8'($urandom_range(0, 30)));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t2_grant", req_ready, 4'b0001 << (c % N));
      if (c > 0) begin
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_id", rsp_id, (c - 1) % N);
      end
      tick();
      set_req(c % N, 1'b1, 24'($urandom_range(0, 24'hFFFFFF)), 8'($urandom_range(0, 30)));
    end
    req_valid = '0;
    tick();

    // Shift amount boundaries
    for (int j = 0; j < 4; j++) begin
      issue(0, t3_m[j], t3_a[j]);
      @(negedge clk);
      check("t3_data", rsp_data, t3_d[j]);
      check("t3_sticky", rsp_sticky, t3_s[j]);
      tick();
    end

    // Backpressure with two waiting requesters
    do_reset();
    rsp_ready = 1'b0;
    issue(0, 24'h123456, 8'd8);
    set_req(1, 1'b1, 24'h00F0F0, 8'd4);
    set_req(2, 1'b1, 24'hFFFFFF, 8'd12);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_stall_ready", req_ready, 4'b0000);
      check("t4_stall_data", rsp_data, 24'h001234);
      check("t4_stall_sticky", rsp_sticky, 1);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_release_ready", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("t4_second_ready", req_ready, 4'b0100);
    check("t4_first_id", rsp_id, 1);
    tick();
    req_valid[2] = 1'b0;
    tick();
    tick();

    // Reset with a pending response and a live request
    rsp_ready = 1'b0;
    issue(0, 24'h0000FF, 8'd4);
    set_req(0, 1'b1, 24'h555555, 8'd1);
    set_req(2, 1'b1, 24'h333333, 8'd2);
    @(negedge clk);
    check("t5_pending", rsp_valid, 1);
    do_reset();
    @(negedge clk);
    check("t5_valid_after_rst", rsp_valid, 0);
    check("t5_data_after_rst", rsp_data, 0);
    check("t5_first_grant", req_ready, 4'b0001);
    rsp_ready = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_next_grant", req_ready, 4'b0100);
    check("t5_rsp_id", rsp_id, 0);
    tick();
    req_valid[2] = 1'b0;
    tick();

    // Pointer wrap from requester 3
    do_reset();
    set_req(3, 1'b1, 24'h00ABCD, 8'd0);
    @(negedge clk);
    check("t6_grant3", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    set_req(1, 1'b1, 24'h010000, 8'd16);
    @(negedge clk);
    check("t6_grant1", req_ready, 4'b0010);
    check("t6_id3", rsp_id, 3);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("t6_id1", rsp_id, 1);
    check("t6_data1", rsp_data, 24'h000001);
    tick();

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, 24'($urandom_range(0, 24'hFFFFFF)),
                  ($urandom_range(0, 7) == 0) ? 8'($urandom_range(24, 255)) : 8'($urandom_range(0, 23)));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
